// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
// The optional HAZARD_PERF_EN build adds performance counters to the interface and top.
package hazard_pkg;

  localparam int unsigned MUL_LAT_MAX = 16;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned PERF_W      = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the datapath, slave the controller.
// HAZARD_PERF_EN adds the three performance counter outputs.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] Rs1D;
  logic [REG_W-1:0] Rs2D;
  logic [REG_W-1:0] Rs1E;
  logic [REG_W-1:0] Rs2E;
  logic [REG_W-1:0] RdE;
  logic [REG_W-1:0] RdM;
  logic [REG_W-1:0] RdW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             LoadE;
  logic             PCSrcE;
  logic             MulStartE;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             MulBusy;
  logic             MulDoneE;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] LwStallCnt;
  logic [PERF_W-1:0] BusyStallCnt;
  logic [PERF_W-1:0] FlushCnt;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MulBusy, MulDoneE
`ifdef HAZARD_PERF_EN
    , input LwStallCnt, BusyStallCnt, FlushCnt
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MulBusy, MulDoneE
`ifdef HAZARD_PERF_EN
    , output LwStallCnt, BusyStallCnt, FlushCnt
`endif
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// One E-stage operand forward select; the M-stage ALU result beats the W-stage result.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output fwd_sel_t         sel_c
);

  always_comb begin
    sel_c = FWD_RF;
    if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) sel_c = FWD_WB;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) sel_c = FWD_MEM;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use stall, branch flush and multi-cycle execute hold.
// Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned CNT_W    = $clog2(MUL_LAT) + 1;
  localparam bit          MULTI    = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  mul_state_t       state;
  mul_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             start_stall;
  logic             hold_stall;
  logic             done_raw;
  logic             busy_stall;
  logic             lw_stall;

  fwd_sel u_fwd_a (
    .rs_e        (hz.Rs1E),
    .rd_m        (hz.RdM),
    .rd_w        (hz.RdW),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .sel_c       (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_e        (hz.Rs2E),
    .rd_m        (hz.RdM),
    .rd_w        (hz.RdW),
    .reg_write_m (hz.RegWriteM),
    .reg_write_w (hz.RegWriteW),
    .sel_c       (fwd_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the remaining stall cycles after the start cycle; cnt==0 in BUSY is the done cycle
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    start_stall = 1'b0;
    hold_stall  = 1'b0;
    done_raw    = 1'b0;
    case (state)
      IDLE: begin
        if (hz.MulStartE) begin
          if (MULTI) begin
            start_stall = 1'b1;
            state_nxt   = BUSY;
            cnt_nxt     = CNT_INIT;
          end else begin
            done_raw = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          hold_stall = 1'b1;
          cnt_nxt    = cnt - CNT_W'(1);
        end else begin
          done_raw  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces the multi-cycle path quiet even while MulStartE is high
  assign busy_stall = reset_n & (start_stall | hold_stall);
  assign lw_stall   = hz.LoadE && (hz.RdE != '0) &&
                      ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  assign hz.ForwardAE = 2'(fwd_a);
  assign hz.ForwardBE = 2'(fwd_b);
  assign hz.StallF    = lw_stall | busy_stall;
  assign hz.StallD    = lw_stall | busy_stall;
  assign hz.StallE    = busy_stall;
  assign hz.FlushM    = busy_stall;
  assign hz.FlushD    = hz.PCSrcE & ~busy_stall;
  assign hz.FlushE    = (lw_stall | hz.PCSrcE) & ~busy_stall;
  assign hz.MulBusy   = (state == BUSY);
  assign hz.MulDoneE  = reset_n & done_raw;

  // A redirect cannot coincide with the start of a multi-cycle op
  mul_branch_excl: assert property (@(posedge clk) disable iff (!reset_n)
                                    !(hz.MulStartE && hz.PCSrcE));

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] lw_cnt;
  logic [PERF_W-1:0] busy_cnt;
  logic [PERF_W-1:0] flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lw_cnt    <= '0;
      busy_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall && !busy_stall) lw_cnt <= lw_cnt + PERF_W'(1);
      if (busy_stall)              busy_cnt <= busy_cnt + PERF_W'(1);
      if (hz.FlushE)               flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign hz.LwStallCnt   = lw_cnt;
  assign hz.BusyStallCnt = busy_cnt;
  assign hz.FlushCnt     = flush_cnt;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core. It drives the stall and flush inputs of the F/D, D/E and E/M pipeline registers, and the forwarding selects of the E-stage operand muxes. Sequencing covers three hazard classes:
- load-use hazards
- taken-branch/jump redirects
- a multi-cycle execute op (MUL/DIV), which holds the D/E register for MUL_LAT cycles.

Parameters:
MUL_LAT, 4, total cycles a multi-cycle op occupies E; legal range 1..16.
CNT_W, $clog2(MUL_LAT)+1, width of the busy counter (localparam, derived).

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
Rs1D  in  5  source reg 1 of instruction in D
Rs2D  in  5  source reg 2 of instruction in D
Rs1E  in  5  source reg 1 of instruction in E
Rs2E  in  5  source reg 2 of instruction in E
RdE  in  5  dest reg of instruction in E
RdM  in  5  dest reg of instruction in M
RdW  in  5  dest reg of instruction in W
RegWriteM  in  1  M-stage writes RF
RegWriteW  in  1  W-stage writes RF
LoadE  in  1  instruction in E is a load (ResultSrcE==mem)
PCSrcE  in  1  taken branch/jump resolved in E
MulStartE  in  1  instruction in E is a multi-cycle op
ForwardAE  out  2  operand A select: 00 RF, 01 W result, 10 M ALU result
ForwardBE  out  2  operand B select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushM  out  1  clear E/M register (bubble into M)
MulBusy  out  1  FSM in BUSY state
MulDoneE  out  1  final cycle of the multi-cycle op; result valid in E

Behaviour:
- **Async reset** (reset_n low): state=IDLE, cnt=0, perf counters=0. While reset is held, MulBusy=0, MulDoneE=0, StallE=0 and FlushM=0. Combinational outputs follow their equations with busyStall=0.
- **Forwarding** (combinational, per operand X in {1,2}):
  - 10 if RegWriteM && RdM!=0 && RdM==RsXE
  - else 01 if RegWriteW && RdW!=0 && RdW==RsXE
  - else 00
  - M has priority over W when both match.
- **Load-use:** lwStall = LoadE && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- **FSM states:** IDLE, BUSY.
  - IDLE: if MulStartE && MUL_LAT>1, then startStall=1; next state=BUSY, cnt<=MUL_LAT-2.
  - BUSY: if cnt!=0, cnt<=cnt-1 and stay. If cnt==0, MulDoneE=1, no busy stall, next state=IDLE.
  - busyStall = startStall | (BUSY && cnt!=0).
  - The op therefore occupies E for exactly MUL_LAT cycles.
  - MUL_LAT==1: never leaves IDLE; MulDoneE = MulStartE.
- **Output equations:**
  - StallF = StallD = lwStall | busyStall
  - StallE = busyStall; FlushM = busyStall
  - FlushD = PCSrcE & ~busyStall
  - FlushE = (lwStall | PCSrcE) & ~busyStall
- **Priority:** busyStall > PCSrcE > lwStall. Flush of E never occurs while a multi-cycle op is held.
- **Back-to-back multi-cycle ops:** the BUSY cnt==0 cycle returns to IDLE, so the next op in E starts a fresh sequence the following cycle. No idle gap is required.
- **Illegal case:** MulStartE && PCSrcE simultaneously is illegal and covered by an assertion; if it occurs, busyStall wins.
- **Reset mid-BUSY:** returns to IDLE immediately; stalls drop in the same cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, add outputs LwStallCnt[31:0], BusyStallCnt[31:0] and FlushCnt[31:0].
- Each counter increments by 1 on every clk edge where lwStall&~busyStall, busyStall, or FlushE respectively is 1.
- Counters wrap at 2^32 and clear on reset.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - mul_state_t enum (IDLE, BUSY)
  - localparam MUL_LAT_MAX=16
- Sub-module fwd_sel: computes one 2-bit forward select from RsXE/RdM/RdW/RegWrite*. Instantiated twice (A, B).

Test Plan:
- **Forwarding:** Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=0 -> 00.
- **Load-use:** LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0. Same stimulus with RdE=0 -> all zero.
- **Branch:** PCSrcE=1, no other hazard -> FlushD=FlushE=1, StallF=0.
- **Multi-cycle op, MUL_LAT=4:** MulStartE=1 at cycle 0 -> StallE=FlushM=StallF=1 in cycles 0-2; MulDoneE=1 and stalls 0 in cycle 3; MulBusy=1 in cycles 1-3.
- **Interaction:** during BUSY, assert LoadE=1, RdE=Rs1D -> FlushE stays 0. Back-to-back op immediately after DONE -> new 4-cycle sequence with no gap.
- **Reset:** reset_n low in the cycle after start -> MulBusy=0, StallE=0 immediately. With HAZARD_PERF_EN, BusyStallCnt=0 after reset and 3 after one MUL_LAT=4 op.
